// File: rtl/call_ret_sequencer.sv
// Micro-op sequencer for CALL/RET/INT/RTI: freezes fetch, injects push/pop
// micro-ops into decode, gathers popped words and ends with a one-cycle PC load.
module call_ret_sequencer #(
    parameter int              DATA_W        = 16,
    parameter int              PC_W          = 32,
    parameter int              OP_W          = 16,
    parameter logic [OP_W-1:0] PUSH_PC_BASE  = 16'h6008,
    parameter logic [OP_W-1:0] POP_PC_BASE   = 16'h7008,
    parameter logic [OP_W-1:0] PUSH_FLAGS_OP = 16'h6010,
    parameter logic [OP_W-1:0] POP_FLAGS_OP  = 16'h7010,
    parameter logic [OP_W-1:0] NOP_OP        = 16'h0000,
    parameter logic [PC_W-1:0] INT_VECTOR    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              call,
    input  logic              ret,
    input  logic              intr,
    input  logic              rti,
    input  logic [DATA_W-1:0] rdst_value,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic [OP_W-1:0]   out_op,
    output logic              op_valid,
    output logic              stall,
    output logic              change_pc,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] flags_out,
    output logic              flags_load,
    output logic              busy
);
    localparam int               PC_WORDS = PC_W / DATA_W;
    localparam int               IDX_W    = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PC_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_PUSHF,
        S_POPF_ISSUE,
        S_POPF_WAIT,
        S_POP_ISSUE,
        S_POP_WAIT,
        S_CHANGE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             is_int;
    logic             pend_int;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  target_merged;
    logic             take_int;
    logic             take_call;
    logic             take_ret;
    logic             take_rti;

    // An interrupt may chain straight out of CHANGE; other requests need IDLE.
    always_comb begin
        take_int  = ((state == S_IDLE) || (state == S_CHANGE)) && (intr || pend_int);
        take_call = (state == S_IDLE) && !take_int && call;
        take_ret  = (state == S_IDLE) && !take_int && !call && ret;
        take_rti  = (state == S_IDLE) && !take_int && !call && !ret && rti;
    end

    // Return PC with the word arriving this cycle already folded in, so the
    // last pop can go straight to CHANGE.
    always_comb begin
        target_merged = target;
        target_merged[int'(idx)*DATA_W +: DATA_W] = mem_data;
    end

    // NOTE: every output is assigned from next-state decisions inside this one
    // clocked block with non-blocking assignments, so all outputs are flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            is_int     <= 1'b0;
            pend_int   <= 1'b0;
            target     <= '0;
            out_op     <= NOP_OP;
            op_valid   <= 1'b0;
            stall      <= 1'b0;
            change_pc  <= 1'b0;
            pc_out     <= '0;
            flags_out  <= '0;
            flags_load <= 1'b0;
            busy       <= 1'b0;
        end else begin
            change_pc  <= 1'b0;
            flags_load <= 1'b0;
            if (intr && (state != S_IDLE)) pend_int <= 1'b1;

            if (take_int) begin
                pend_int <= 1'b0;
                is_int   <= 1'b1;
                target   <= INT_VECTOR;
                idx      <= '0;
                state    <= S_PUSH;
                out_op   <= PUSH_PC_BASE;
                op_valid <= 1'b1;
                stall    <= 1'b1;
                busy     <= 1'b1;
            end else if (take_call) begin
                is_int   <= 1'b0;
                target   <= PC_W'(rdst_value);
                idx      <= '0;
                state    <= S_PUSH;
                out_op   <= PUSH_PC_BASE;
                op_valid <= 1'b1;
                stall    <= 1'b1;
                busy     <= 1'b1;
            end else if (take_ret) begin
                idx      <= LAST_IDX;
                state    <= S_POP_ISSUE;
                out_op   <= POP_PC_BASE + OP_W'(LAST_IDX);
                op_valid <= 1'b1;
                stall    <= 1'b1;
                busy     <= 1'b1;
            end else if (take_rti) begin
                state    <= S_POPF_ISSUE;
                out_op   <= POP_FLAGS_OP;
                op_valid <= 1'b1;
                stall    <= 1'b1;
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        out_op   <= NOP_OP;
                        op_valid <= 1'b0;
                    end
                    S_PUSH: begin
                        if (idx != LAST_IDX) begin
                            idx    <= idx + 1'b1;
                            out_op <= PUSH_PC_BASE + OP_W'(idx + 1'b1);
                        end else if (is_int) begin
                            state  <= S_PUSHF;
                            out_op <= PUSH_FLAGS_OP;
                        end else begin
                            state     <= S_CHANGE;
                            change_pc <= 1'b1;
                            pc_out    <= target;
                            out_op    <= NOP_OP;
                            op_valid  <= 1'b0;
                        end
                    end
                    S_PUSHF: begin
                        state     <= S_CHANGE;
                        change_pc <= 1'b1;
                        pc_out    <= target;
                        out_op    <= NOP_OP;
                        op_valid  <= 1'b0;
                    end
                    S_POPF_ISSUE, S_POPF_WAIT: begin
                        if (mem_valid) begin
                            flags_out  <= mem_data;
                            flags_load <= 1'b1;
                            idx        <= LAST_IDX;
                            state      <= S_POP_ISSUE;
                            out_op     <= POP_PC_BASE + OP_W'(LAST_IDX);
                            op_valid   <= 1'b1;
                        end else begin
                            state    <= S_POPF_WAIT;
                            out_op   <= NOP_OP;
                            op_valid <= 1'b0;
                        end
                    end
                    S_POP_ISSUE, S_POP_WAIT: begin
                        if (!mem_valid) begin
                            state    <= S_POP_WAIT;
                            out_op   <= NOP_OP;
                            op_valid <= 1'b0;
                        end else if (idx == '0) begin
                            target    <= target_merged;
                            state     <= S_CHANGE;
                            change_pc <= 1'b1;
                            pc_out    <= target_merged;
                            out_op    <= NOP_OP;
                            op_valid  <= 1'b0;
                        end else begin
                            target   <= target_merged;
                            idx      <= idx - 1'b1;
                            state    <= S_POP_ISSUE;
                            out_op   <= POP_PC_BASE + OP_W'(idx - 1'b1);
                            op_valid <= 1'b1;
                        end
                    end
                    S_CHANGE: begin
                        state <= S_IDLE;
                        stall <= 1'b0;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Self-checking bench for call_ret_sequencer: a per-cycle vector table run
// through an expectation queue, plus randomised-latency RET sequences.
module tb_call_ret_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        intr = 1'b0;
    logic        rti = 1'b0;
    logic        mem_valid = 1'b0;
    logic [15:0] rdst_value = '0;
    logic [15:0] mem_data = '0;
    logic [15:0] out_op;
    logic        op_valid;
    logic        stall;
    logic        change_pc;
    logic [31:0] pc_out;
    logic [15:0] flags_out;
    logic        flags_load;
    logic        busy;

    call_ret_sequencer #(
        .DATA_W    (16),
        .PC_W      (32),
        .OP_W      (16),
        .INT_VECTOR(32'h0000_0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call      (call),
        .ret       (ret),
        .intr      (intr),
        .rti       (rti),
        .rdst_value(rdst_value),
        .mem_data  (mem_data),
        .mem_valid (mem_valid),
        .out_op    (out_op),
        .op_valid  (op_valid),
        .stall     (stall),
        .change_pc (change_pc),
        .pc_out    (pc_out),
        .flags_out (flags_out),
        .flags_load(flags_load),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // in  = {reset, call, ret, intr, rti}; ctl = {op_valid, stall, change_pc, flags_load, busy}
    typedef struct {
        logic [4:0]  in;
        logic [15:0] rd;
        logic        mv;
        logic [15:0] md;
        logic [15:0] op;
        logic [4:0]  ctl;
        logic [31:0] pc;
        logic [15:0] fo;
    } vec_t;

    vec_t        vecs[$];
    string       names[$];
    vec_t        exp_q[$];
    logic [31:0] pc_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic add(input string nm, input logic [4:0] in, input logic [15:0] rd,
                       input logic mv, input logic [15:0] md, input logic [15:0] op,
                       input logic [4:0] ctl, input logic [31:0] pc, input logic [15:0] fo);
        vec_t v;
        v.in = in; v.rd = rd; v.mv = mv; v.md = md;
        v.op = op; v.ctl = ctl; v.pc = pc; v.fo = fo;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        vec_t       e;
        logic       chk_pc;
        logic       chk_fl;
        logic       bad;
        logic [4:0] ctl_now;
        @(negedge clk);
        {reset, call, ret, intr, rti} = v.in;
        rdst_value = v.rd;
        mem_valid  = v.mv;
        mem_data   = v.md;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e       = exp_q.pop_front();
        ctl_now = {op_valid, stall, change_pc, flags_load, busy};
        // pc_out/flags_out are only meaningful on their pulses and right after reset
        chk_pc  = e.ctl[2] | ~e.in[4];
        chk_fl  = e.ctl[1] | ~e.in[4];
        bad = (out_op !== e.op) || (ctl_now !== e.ctl) ||
              (chk_pc && (pc_out !== e.pc)) || (chk_fl && (flags_out !== e.fo));
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got op=%h ctl=%b pc=%h fo=%h, expected op=%h ctl=%b pc=%h fo=%h",
                     nm, out_op, ctl_now, pc_out, flags_out, e.op, e.ctl, e.pc, e.fo);
        end
    endtask

    task automatic rand_ret();
        logic [15:0] words[2];
        int          lat;
        words[0] = 16'($urandom);
        words[1] = 16'($urandom);
        pc_q.push_back({words[1], words[0]});
        @(negedge clk);
        ret = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        ret = 1'b0;
        for (int w = 1; w >= 0; w--) begin
            check("rnd_pop_op", 32'({op_valid, out_op}), 32'({1'b1, 16'h7008 + 16'(w)}));
            lat = $urandom_range(0, 6);
            for (int k = 0; k < lat; k++) begin
                mem_valid = 1'b0;
                @(negedge clk);
                check("rnd_wait", 32'({op_valid, stall, busy}), 32'(3'b011));
            end
            mem_valid = 1'b1;
            mem_data  = words[w];
            @(negedge clk);
            mem_valid = 1'b0;
        end
        check("rnd_chg", 32'({change_pc, stall, op_valid}), 32'(3'b110));
        check("rnd_pc", pc_out, pc_q.pop_front());
        @(negedge clk);
        check("rnd_end", 32'({stall, busy}), 32'(2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at time %0t", $time);
        $fatal(1);
    end

    initial begin
        add("reset",     5'b00000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        add("idle",      5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // CALL to 0x1234: two pushes then CHANGE, stall exactly 3 cycles
        add("call_w0",   5'b11000, 16'h1234, 1'b0, 16'h0000, 16'h6008, 5'b11001, 32'h0, 16'h0000);
        add("call_w1",   5'b10000, 16'h1234, 1'b0, 16'h0000, 16'h6009, 5'b11001, 32'h0, 16'h0000);
        add("call_chg",  5'b10000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 5'b01101, 32'h0000_1234, 16'h0000);
        add("call_end",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // RET with memory answering two cycles after each pop
        add("ret_pop1",  5'b10100, 16'h0000, 1'b0, 16'h0000, 16'h7009, 5'b11001, 32'h0, 16'h0000);
        add("ret_wt1a",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01001, 32'h0, 16'h0000);
        add("ret_wt1b",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01001, 32'h0, 16'h0000);
        add("ret_pop0",  5'b10000, 16'h0000, 1'b1, 16'h00AB, 16'h7008, 5'b11001, 32'h0, 16'h0000);
        add("ret_wt0a",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01001, 32'h0, 16'h0000);
        add("ret_wt0b",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01001, 32'h0, 16'h0000);
        add("ret_chg",   5'b10000, 16'h0000, 1'b1, 16'hCD00, 16'h0000, 5'b01101, 32'h00AB_CD00, 16'h0000);
        add("ret_end",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        add("mv_idle",   5'b10000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // INT to 0x100: two pushes, push-flags, CHANGE
        add("int_w0",    5'b10010, 16'h0000, 1'b0, 16'h0000, 16'h6008, 5'b11001, 32'h0, 16'h0000);
        add("int_w1",    5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h6009, 5'b11001, 32'h0, 16'h0000);
        add("int_pf",    5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h6010, 5'b11001, 32'h0, 16'h0000);
        add("int_chg",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01101, 32'h0000_0100, 16'h0000);
        add("int_end",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // RTI with zero-latency memory
        add("rti_popf",  5'b10001, 16'h0000, 1'b0, 16'h0000, 16'h7010, 5'b11001, 32'h0, 16'h0000);
        add("rti_pop1",  5'b10000, 16'h0000, 1'b1, 16'h0005, 16'h7009, 5'b11011, 32'h0, 16'h0005);
        add("rti_pop0",  5'b10000, 16'h0000, 1'b1, 16'h0001, 16'h7008, 5'b11001, 32'h0, 16'h0000);
        add("rti_chg",   5'b10000, 16'h0000, 1'b1, 16'h0200, 16'h0000, 5'b01101, 32'h0001_0200, 16'h0000);
        add("rti_end",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // call+ret+intr together: INT wins; held call/ret ignored until IDLE
        add("pri_w0",    5'b11110, 16'h5555, 1'b0, 16'h0000, 16'h6008, 5'b11001, 32'h0, 16'h0000);
        add("pri_w1",    5'b11100, 16'h5555, 1'b0, 16'h0000, 16'h6009, 5'b11001, 32'h0, 16'h0000);
        add("pri_pf",    5'b11100, 16'h5555, 1'b0, 16'h0000, 16'h6010, 5'b11001, 32'h0, 16'h0000);
        add("pri_chg",   5'b11100, 16'h5555, 1'b0, 16'h0000, 16'h0000, 5'b01101, 32'h0000_0100, 16'h0000);
        add("pri_gap",   5'b11100, 16'h5555, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // held call now accepted; intr during it is pended and chains from CHANGE
        add("held_w0",   5'b11000, 16'h5555, 1'b0, 16'h0000, 16'h6008, 5'b11001, 32'h0, 16'h0000);
        add("pend_w1",   5'b10010, 16'h0000, 1'b0, 16'h0000, 16'h6009, 5'b11001, 32'h0, 16'h0000);
        add("pend_chg",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01101, 32'h0000_5555, 16'h0000);
        add("pend_w0",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h6008, 5'b11001, 32'h0, 16'h0000);
        add("pend_w1b",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h6009, 5'b11001, 32'h0, 16'h0000);
        add("pend_pf",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h6010, 5'b11001, 32'h0, 16'h0000);
        add("pend_chg2", 5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01101, 32'h0000_0100, 16'h0000);
        add("pend_end",  5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        // reset while in POP_WAIT with an interrupt pending
        add("rr_pop1",   5'b10100, 16'h0000, 1'b0, 16'h0000, 16'h7009, 5'b11001, 32'h0, 16'h0000);
        add("rr_wait",   5'b10010, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b01001, 32'h0, 16'h0000);
        add("rr_reset",  5'b00000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);
        add("rr_idle",   5'b10000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 5'b00000, 32'h0, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) apply(names[i], vecs[i]);
        for (int r = 0; r < 3; r++) rand_ret();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
